uart_mmio_ctrl: RTL and testbench
=================================

Name: uart_mmio_ctrl

Overview:
Memory-mapped register controller that sits between the CPU load/store port and uart_unit. It decodes a 16-byte register window and turns CPU stores into one-cycle uart_fifo_write_en pulses. It stalls stores while the TX FIFO is full, with a timeout, and pops RX bytes with cpu_read pulses. It also provides status/control registers and a level interrupt.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; hit when mem_addr[31:4] == BASE_ADDR[31:4].
STALL_LIMIT, 1024, maximum cycles a TXDATA store waits for tx_ready before being dropped.
RX_MASK_CYCLES, 2, cycles rx_ready is masked after a pop, covering the uart_unit clear latency.

Ports:
clk  in  1  system clock
rst  in  1  reset
mem_addr  in  32  CPU byte address; bits [3:2] select the register, [1:0] are ignored
mem_wdata  in  32  store data
mem_we  in  1  store request, held until mem_ready
mem_re  in  1  load request, held until mem_ready
mem_rdata  out  32  load data, valid while mem_ready=1
mem_ready  out  1  one-cycle completion pulse
uart_fifo_write_en  out  1  one-cycle TX FIFO push to uart_unit
uart_fifo_data  out  8  TX byte
cpu_read  out  1  one-cycle RX pop to uart_unit
tx_ready  in  1  uart_unit TX FIFO not full
rx_ready  in  1  uart_unit RX byte available
rx_data_output  in  32  uart_unit RX byte, zero-extended
irq  out  1  level interrupt

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; mem_ready=0; mem_rdata=0; uart_fifo_write_en=0; uart_fifo_data=0; cpu_read=0; irq=0; CTRL=0; tx_drop=0; stall_cnt=0; rx_mask_cnt=0.
- Reset mid-stall or mid-response aborts the access: no write pulse and no mem_ready.
- Register map (offset = mem_addr[3:2]*4):
  - 0x0 TXDATA (W): writes mem_wdata[7:0]. Reads return 0.
  - 0x4 RXDATA (R): if rx_eff=1, returns rx_data_output and pops; otherwise returns 32'hFFFF_FFFF with no pop. Writes are ignored.
  - 0x8 STATUS (R/W1C): bit0 rx_eff, bit1 tx_ready, bit2 tx_drop (sticky), bit3 irq; other bits 0. Writing 1 to bit2 clears tx_drop.
  - 0xC CTRL (RW): bit0 rx_irq_en, bit1 tx_irq_en; other bits read 0.
- rx_eff = rx_ready & (rx_mask_cnt==0).
- irq (registered): next value is (rx_irq_en & rx_eff) | (tx_irq_en & tx_ready).
- All outputs are registered.
- FSM states: IDLE, TX_STALL, RESP.
- IDLE:
  - A request is sampled only in IDLE, and only on an address hit.
  - Non-hit requests are ignored: no response.
  - If mem_we and mem_re are both set, the store wins and the load is ignored.
- IDLE, hit store to TXDATA with tx_ready=1: next cycle uart_fifo_write_en=1, uart_fifo_data=mem_wdata[7:0], mem_ready=1; go to RESP.
- IDLE, hit store to TXDATA with tx_ready=0: go to TX_STALL with stall_cnt=0.
- IDLE, any other hit: perform the register access; mem_ready=1 next cycle with mem_rdata; go to RESP.
  - An RXDATA pop also drives cpu_read=1 for that cycle and loads rx_mask_cnt=RX_MASK_CYCLES.
- TX_STALL:
  - stall_cnt++ each cycle.
  - tx_ready=1: push the byte as above, mem_ready=1, go to RESP.
  - Else when stall_cnt==STALL_LIMIT-1: no push; set tx_drop=1; mem_ready=1; go to RESP.
  - tx_ready takes priority over the timeout in the same cycle.
- RESP: mem_ready, uart_fifo_write_en and cpu_read all return to 0; go to IDLE. The CPU must drop its request at the edge where it sees mem_ready. Minimum access time is 2 cycles (IDLE→RESP→IDLE).
- rx_mask_cnt decrements to 0 each cycle. Back-to-back RXDATA reads therefore never pop the same byte twice.
- Write-1-to-clear of tx_drop in the same cycle as a timeout: the set wins.
- CTRL writes take effect on irq one cycle after the mem_ready cycle.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets UART_TXDATA/RXDATA/STATUS/CTRL;
  - STATUS bit indices (ST_RX_RDY=0, ST_TX_RDY=1, ST_TX_DROP=2, ST_IRQ=3);
  - CTRL bit indices;
  - the FSM state encoding;
  - the RX-empty value 32'hFFFF_FFFF.
- No sub-module is needed; uart_unit is instantiated next to this block at SoC level.

Test Plan:
- Store 0x41 to BASE+0x0 with tx_ready=1 -> exactly one uart_fifo_write_en pulse with data 0x41, mem_ready 1 cycle after the request is sampled, single pulse.
- tx_ready=0 for 10 cycles, then 1; store 0x42 -> no push while stalled; push 0x42 and mem_ready in the cycle after tx_ready rises; tx_drop stays 0.
- tx_ready held 0, STALL_LIMIT=16; store -> mem_ready after 16 stall cycles, no push, STATUS read returns 0x4; write 0x4 to STATUS -> next STATUS read returns 0x0.
- rx_ready=1 with rx_data_output=0x5A; two back-to-back RXDATA loads; uart clears rx_ready 1 cycle after cpu_read -> first returns 0x5A with one cpu_read pulse; second returns 0xFFFF_FFFF with no cpu_read.
- CTRL=0x1, then rx_ready rises -> irq=1 next cycle; pop the byte -> irq=0 within RX_MASK_CYCLES; CTRL=0x2 with tx_ready=1 -> irq=1.
- Assert rst during TX_STALL -> next cycle mem_ready=0, no push, CTRL=0, state IDLE; a non-hit address (BASE+0x10) -> no mem_ready ever.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared register offsets, bit indices, FSM encoding and helpers
//             for the UART memory-mapped register controller.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register select values taken from mem_addr[3:2] (byte offset = value*4)
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    // STATUS register bit positions
    localparam int ST_RX_RDY  = 0;
    localparam int ST_TX_RDY  = 1;
    localparam int ST_TX_DROP = 2;
    localparam int ST_IRQ     = 3;

    // CTRL register bit positions
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // Access sequencer state encoding
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_TX_STALL = 2'd1;
    localparam logic [1:0] S_RESP     = 2'd2;

    // Value returned by an RXDATA load when no byte is available
    localparam logic [31:0] RX_EMPTY_VALUE = 32'hFFFF_FFFF;

    // Assemble the STATUS read word from its individual flags
    function automatic logic [31:0] status_word(
        input logic rx_eff,
        input logic tx_rdy,
        input logic tx_drop,
        input logic irq_lvl
    );
        logic [31:0] w;
        w             = 32'd0;
        w[ST_RX_RDY]  = rx_eff;
        w[ST_TX_RDY]  = tx_rdy;
        w[ST_TX_DROP] = tx_drop;
        w[ST_IRQ]     = irq_lvl;
        return w;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_ctrl
//  Purpose  : CPU load/store to uart_unit bridge. Decodes a 16-byte register
//             window, pushes TX bytes (stalling while the FIFO is full, with
//             a drop timeout), pops RX bytes, and drives a level interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          STALL_LIMIT    = 1024,
    parameter int          RX_MASK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        uart_fifo_write_en,
    output logic [7:0]  uart_fifo_data,
    output logic        cpu_read,
    input  logic        tx_ready,
    input  logic        rx_ready,
    input  logic [31:0] rx_data_output,
    output logic        irq
);

    // Counter widths sized to hold the largest value each counter reaches
    localparam int STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT);
    localparam int MASK_W  = $clog2(RX_MASK_CYCLES + 1) < 1 ? 1 : $clog2(RX_MASK_CYCLES + 1);

    localparam logic [STALL_W-1:0] C_STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [MASK_W-1:0]  C_MASK_LOAD  = MASK_W'(RX_MASK_CYCLES);

    // Registered state
    logic [1:0]         r_state;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [MASK_W-1:0]  r_rx_mask_cnt;
    logic [1:0]         r_ctrl;
    logic               r_tx_drop;
    logic [7:0]         r_tx_byte;
    logic [31:0]        r_mem_rdata;
    logic               r_mem_ready;
    logic               r_fifo_we;
    logic [7:0]         r_fifo_data;
    logic               r_cpu_read;
    logic               r_irq;

    // Combinational decode
    logic        w_hit;
    logic        w_req;
    logic [1:0]  w_reg;
    logic        w_rx_eff;
    logic        w_irq_next;
    logic        w_drop_set;
    logic        w_drop_clr;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_req      = w_hit && (mem_we || mem_re);
    assign w_reg      = mem_addr[3:2];
    // The mask hides the stale rx_ready that uart_unit still shows after a pop
    assign w_rx_eff   = rx_ready && (r_rx_mask_cnt == '0);
    assign w_irq_next = (r_ctrl[CTRL_RX_IRQ_EN] && w_rx_eff) ||
                        (r_ctrl[CTRL_TX_IRQ_EN] && tx_ready);

    // Sticky drop flag: timeout sets it, STATUS write-one clears it
    assign w_drop_set = (r_state == S_TX_STALL) && !tx_ready && (r_stall_cnt == C_STALL_LAST);
    assign w_drop_clr = (r_state == S_IDLE) && w_req && mem_we &&
                        (w_reg == UART_STATUS) && mem_wdata[ST_TX_DROP];

    // Byte-lane and data bits this block never looks at
    assign w_unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    // Load data multiplexer for the addressed register
    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            UART_TXDATA: w_rdata = 32'd0;
            UART_RXDATA: w_rdata = w_rx_eff ? rx_data_output : RX_EMPTY_VALUE;
            UART_STATUS: w_rdata = status_word(w_rx_eff, tx_ready, r_tx_drop, r_irq);
            UART_CTRL:   w_rdata = {30'd0, r_ctrl};
            default:     w_rdata = 32'd0;
        endcase
    end

    // Drop flag register; a same-cycle set beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_drop <= 1'b0;
        end else if (w_drop_set) begin
            r_tx_drop <= 1'b1;
        end else if (w_drop_clr) begin
            r_tx_drop <= 1'b0;
        end
    end

    // Interrupt level and RX pop mask countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq         <= 1'b0;
            r_rx_mask_cnt <= '0;
        end else begin
            r_irq <= w_irq_next;
            if (r_cpu_read_load()) begin
                r_rx_mask_cnt <= C_MASK_LOAD;
            end else if (r_rx_mask_cnt != '0) begin
                r_rx_mask_cnt <= r_rx_mask_cnt - MASK_W'(1);
            end
        end
    end

    // True on the cycle an RXDATA load with a byte available is accepted
    function automatic logic r_cpu_read_load();
        return (r_state == S_IDLE) && w_req && !mem_we &&
               (w_reg == UART_RXDATA) && w_rx_eff;
    endfunction

    // Access sequencer: accept, stall on full TX FIFO, respond for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
            r_ctrl      <= 2'd0;
            r_tx_byte   <= 8'd0;
            r_mem_rdata <= 32'd0;
            r_mem_ready <= 1'b0;
            r_fifo_we   <= 1'b0;
            r_fifo_data <= 8'd0;
            r_cpu_read  <= 1'b0;
        end else begin
            r_mem_ready <= 1'b0;
            r_fifo_we   <= 1'b0;
            r_cpu_read  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (mem_we) begin
                            r_mem_rdata <= 32'd0;
                            if (w_reg == UART_TXDATA) begin
                                r_tx_byte <= mem_wdata[7:0];
                                if (tx_ready) begin
                                    r_fifo_we   <= 1'b1;
                                    r_fifo_data <= mem_wdata[7:0];
                                    r_mem_ready <= 1'b1;
                                    r_state     <= S_RESP;
                                end else begin
                                    r_stall_cnt <= '0;
                                    r_state     <= S_TX_STALL;
                                end
                            end else begin
                                if (w_reg == UART_CTRL) begin
                                    r_ctrl <= mem_wdata[1:0];
                                end
                                r_mem_ready <= 1'b1;
                                r_state     <= S_RESP;
                            end
                        end else begin
                            r_mem_rdata <= w_rdata;
                            r_mem_ready <= 1'b1;
                            r_cpu_read  <= r_cpu_read_load();
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_TX_STALL: begin
                    if (tx_ready) begin
                        r_fifo_we   <= 1'b1;
                        r_fifo_data <= r_tx_byte;
                        r_mem_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_stall_cnt == C_STALL_LAST) begin
                        r_mem_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rdata          = r_mem_rdata;
    assign mem_ready          = r_mem_ready;
    assign uart_fifo_write_en = r_fifo_we;
    assign uart_fifo_data     = r_fifo_data;
    assign cpu_read           = r_cpu_read;
    assign irq                = r_irq;

endmodule : uart_mmio_ctrl
`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mmio_ctrl
//  Purpose  : Self-checking bench for uart_mmio_ctrl with a behavioural
//             register/UART model and randomized accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_ctrl;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          LIMIT = 16;
    localparam int          MASKC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        uart_fifo_write_en;
    logic [7:0]  uart_fifo_data;
    logic        cpu_read;
    logic        tx_ready;
    logic        rx_ready;
    logic [31:0] rx_data_output;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int stray    = 0;
    logic rx_auto_clear = 1'b1;

    // Model state: what the registers should hold
    logic [1:0] m_ctrl;
    logic       m_drop;

    // Results of the most recent access
    logic        a_done;
    logic [31:0] a_rdata;
    int          a_lat;
    int          a_push;
    logic [7:0]  a_byte;
    int          a_pop;

    uart_mmio_ctrl #(
        .BASE_ADDR      (BASE),
        .STALL_LIMIT    (LIMIT),
        .RX_MASK_CYCLES (MASKC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_we             (mem_we),
        .mem_re             (mem_re),
        .mem_rdata          (mem_rdata),
        .mem_ready          (mem_ready),
        .uart_fifo_write_en (uart_fifo_write_en),
        .uart_fifo_data     (uart_fifo_data),
        .cpu_read           (cpu_read),
        .tx_ready           (tx_ready),
        .rx_ready           (rx_ready),
        .rx_data_output     (rx_data_output),
        .irq                (irq)
    );

    always #5 clk = ~clk;

    // Idle cycles; any pulse seen while no access is outstanding is stray
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mem_ready || uart_fifo_write_en || cpu_read) stray++;
        end
    endtask

    // One CPU access. tx_delay>=0 drives tx_ready low until the tx_delay-th
    // sampling edge after the request; tx_delay<0 leaves tx_ready alone.
    task automatic access(input logic [31:0] addr, input logic we, input logic re,
                          input logic [31:0] wdata, input int tx_delay, input int max_cyc);
        mem_addr  = addr;
        mem_we    = we;
        mem_re    = re;
        mem_wdata = wdata;
        if (tx_delay >= 0) tx_ready = (tx_delay == 0);
        a_done = 1'b0; a_rdata = 32'd0; a_lat = 0; a_push = 0; a_byte = 8'd0; a_pop = 0;
        for (int j = 1; j <= max_cyc && !a_done; j++) begin
            @(negedge clk);
            if (uart_fifo_write_en) begin a_push++; a_byte = uart_fifo_data; end
            if (cpu_read) begin a_pop++; if (rx_auto_clear) rx_ready = 1'b0; end
            if (mem_ready) begin a_done = 1'b1; a_lat = j; a_rdata = mem_rdata; end
            else if (tx_delay >= 0) tx_ready = (j >= tx_delay);
        end
        mem_we = 1'b0;
        mem_re = 1'b0;
        if (a_done) idle(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_addr = 32'd0; mem_wdata = 32'd0; mem_we = 1'b0; mem_re = 1'b0;
        tx_ready = 1'b0; rx_ready = 1'b0; rx_data_output = 32'd0;
        m_ctrl = 2'd0; m_drop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_ready, uart_fifo_write_en, cpu_read, irq, uart_fifo_data, mem_rdata} !== 44'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b we=%b rd=%b irq=%b data=%h rdata=%h, want all 0",
                     mem_ready, uart_fifo_write_en, cpu_read, irq, uart_fifo_data, mem_rdata);
        end
        access(BASE + 32'hC, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (!a_done || a_rdata !== 32'd0 || a_lat != 1) begin
            failures++;
            $display("FAIL reset_ctrl: done=%b rdata=%h lat=%0d, want 1 00000000 1", a_done, a_rdata, a_lat);
        end
    endtask

    // Expected store-to-TXDATA outcome from the FIFO-ready delay
    task automatic tx_store(input logic [7:0] b, input int d, input string nm);
        int exp_lat;
        int exp_push;
        access(BASE, 1'b1, 1'b0, {24'hABCDEF, b}, d, 200);
        exp_push = (d <= LIMIT) ? 1 : 0;
        exp_lat  = (d <= LIMIT) ? d + 1 : LIMIT + 1;
        if (d > LIMIT) m_drop = 1'b1;
        checks++;
        if (!a_done || a_lat != exp_lat || a_push != exp_push ||
            (exp_push == 1 && a_byte !== b)) begin
            failures++;
            $display("FAIL %s: done=%b lat=%0d push=%0d byte=%h, want lat=%0d push=%0d byte=%h (d=%0d)",
                     nm, a_done, a_lat, a_push, a_byte, exp_lat, exp_push, b, d);
        end
    endtask

    // STATUS read against the model once inputs have been steady a few cycles
    task automatic status_check(input string nm);
        logic [31:0] exp;
        logic        exp_irq;
        idle(3);
        exp_irq = (m_ctrl[0] & rx_ready) | (m_ctrl[1] & tx_ready);
        exp = {28'd0, exp_irq, m_drop, tx_ready, rx_ready};
        access(BASE + 32'h8, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (!a_done || a_rdata !== exp || a_pop != 0) begin
            failures++;
            $display("FAIL %s: done=%b status=%h pop=%0d, want %h", nm, a_done, a_rdata, a_pop, exp);
        end
        checks++;
        if (irq !== exp_irq) begin
            failures++;
            $display("FAIL %s_irq: irq=%b want %b", nm, irq, exp_irq);
        end
    endtask

    task automatic test_tx_basic();
        idle(2);
        tx_store(8'h41, 0, "tx_basic");
    endtask

    task automatic test_tx_stall();
        tx_store(8'h42, 10, "tx_stall");
        status_check("tx_stall_status");
    endtask

    task automatic test_tx_timeout();
        tx_store(8'h43, 1000, "tx_timeout");
        tx_ready = 1'b0;
        idle(3);
        access(BASE + 32'h8, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (a_rdata !== 32'h4) begin
            failures++;
            $display("FAIL timeout_status: got %h want 00000004", a_rdata);
        end
        access(BASE + 32'h8, 1'b1, 1'b0, 32'h4, -1, 50);
        m_drop = 1'b0;
        access(BASE + 32'h8, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (a_rdata !== 32'h0) begin
            failures++;
            $display("FAIL w1c_status: got %h want 00000000", a_rdata);
        end
    endtask

    task automatic test_back_to_back();
        rx_auto_clear = 1'b1;
        rx_data_output = 32'h5A; rx_ready = 1'b1;
        idle(3);
        access(BASE + 32'h4, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (a_rdata !== 32'h5A || a_pop != 1) begin
            failures++;
            $display("FAIL b2b_first: got %h pops=%0d want 0000005a pops=1", a_rdata, a_pop);
        end
        access(BASE + 32'h4, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (a_rdata !== 32'hFFFF_FFFF || a_pop != 0) begin
            failures++;
            $display("FAIL b2b_second: got %h pops=%0d want ffffffff pops=0", a_rdata, a_pop);
        end
        // uart_unit slow to clear: the mask alone must prevent a double pop
        rx_auto_clear = 1'b0;
        rx_data_output = 32'h77; rx_ready = 1'b1;
        idle(3);
        access(BASE + 32'h4, 1'b0, 1'b1, 32'd0, -1, 50);
        access(BASE + 32'h4, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (a_rdata !== 32'hFFFF_FFFF || a_pop != 0) begin
            failures++;
            $display("FAIL mask_second: got %h pops=%0d want ffffffff pops=0", a_rdata, a_pop);
        end
        access(BASE + 32'h4, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (a_rdata !== 32'h77 || a_pop != 1) begin
            failures++;
            $display("FAIL mask_third: got %h pops=%0d want 00000077 pops=1", a_rdata, a_pop);
        end
        rx_ready = 1'b0;
        rx_auto_clear = 1'b1;
        idle(3);
    endtask

    task automatic test_irq();
        tx_ready = 1'b0;
        access(BASE + 32'hC, 1'b1, 1'b0, 32'h1, -1, 50);
        m_ctrl = 2'd1;
        idle(2);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle: irq=%b want 0", irq); end
        rx_data_output = 32'hC3; rx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx: irq=%b want 1", irq); end
        access(BASE + 32'h4, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (irq !== 1'b0 || a_rdata !== 32'hC3) begin
            failures++;
            $display("FAIL irq_pop: irq=%b rdata=%h want irq=0 rdata=000000c3", irq, a_rdata);
        end
        tx_ready = 1'b1;
        access(BASE + 32'hC, 1'b1, 1'b0, 32'h2, -1, 50);
        m_ctrl = 2'd2;
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx: irq=%b want 1", irq); end
    endtask

    task automatic test_random();
        int op;
        logic [31:0] v;
        logic [31:0] exp;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            v  = $urandom;
            case (op)
                0: tx_store(v[7:0], $urandom_range(0, 20), "rnd_tx");
                1: begin
                    rx_ready = v[31]; rx_data_output = $urandom;
                    idle(3);
                    exp = rx_ready ? rx_data_output : 32'hFFFF_FFFF;
                    access(BASE + 32'h4, 1'b0, 1'b1, 32'd0, -1, 50);
                    checks++;
                    if (!a_done || a_rdata !== exp || a_pop != (exp == 32'hFFFF_FFFF && !v[31] ? 0 : 1)) begin
                        failures++;
                        $display("FAIL rnd_rx: got %h pops=%0d want %h", a_rdata, a_pop, exp);
                    end
                end
                2: begin
                    access(BASE + 32'hC, 1'b1, 1'b0, v, -1, 50);
                    m_ctrl = v[1:0];
                    access(BASE + 32'hC, 1'b0, 1'b1, 32'd0, -1, 50);
                    checks++;
                    if (a_rdata !== {30'd0, m_ctrl}) begin
                        failures++;
                        $display("FAIL rnd_ctrl: got %h want %h", a_rdata, {30'd0, m_ctrl});
                    end
                end
                3: begin
                    access(BASE + 32'h8, 1'b1, 1'b0, v, -1, 50);
                    if (v[2]) m_drop = 1'b0;
                    status_check("rnd_status");
                end
                default: begin
                    // Store and load together on RXDATA: the store wins, nothing pops
                    rx_ready = 1'b1; rx_data_output = v;
                    idle(3);
                    access(BASE + 32'h4, 1'b1, 1'b1, v, -1, 50);
                    checks++;
                    if (!a_done || a_lat != 1 || a_pop != 0 || a_push != 0 || rx_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_we_re: done=%b lat=%0d pop=%0d push=%0d, want 1 1 0 0",
                                 a_done, a_lat, a_pop, a_push);
                    end
                end
            endcase
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_midstall();
        int seen;
        access(BASE + 32'hC, 1'b1, 1'b0, 32'h3, -1, 50);
        @(negedge clk);
        mem_addr = BASE; mem_wdata = 32'h77; mem_we = 1'b1; tx_ready = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_ready || uart_fifo_write_en) seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (mem_ready || uart_fifo_write_en) seen++;
        mem_we = 1'b0; rst = 1'b0; tx_ready = 1'b1;
        m_ctrl = 2'd0; m_drop = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready || uart_fifo_write_en) seen++;
        end
        checks++;
        if (seen != 0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: pulses=%0d irq=%b want 0 0", seen, irq);
        end
        access(BASE + 32'hC, 1'b0, 1'b1, 32'd0, -1, 50);
        checks++;
        if (!a_done || a_lat != 1 || a_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_idle_ctrl: done=%b lat=%0d ctrl=%h want 1 1 0", a_done, a_lat, a_rdata);
        end
        access(BASE + 32'h10, 1'b1, 1'b1, 32'h55, -1, 40);
        checks++;
        if (a_done || a_push != 0 || a_pop != 0) begin
            failures++;
            $display("FAIL nonhit: done=%b push=%0d pop=%0d want 0 0 0", a_done, a_push, a_pop);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_stall();
        test_tx_timeout();
        test_back_to_back();
        test_irq();
        test_random();
        test_reset_midstall();
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL no_stray: got %0d unsolicited pulses want 0", stray);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_mmio_ctrl
`default_nettype wire
